// File: rtl/csv_accum_ctrl.sv
// Job accumulator: streams N operands through one carry-save compressor whose
// last two inputs are the registered S/C pair, then resolves S+C into a word.
module csv_accum_ctrl #(
  parameter int width     = 16,
  parameter int depth     = 4,
  parameter int max_count = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_valid_i,
  output logic                           start_ready_o,
  input  logic [$clog2(max_count+1)-1:0] count_i,
  input  logic                           op_valid_i,
  output logic                           op_ready_o,
  input  logic [width-1:0]               op_data_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [width-1:0]               res_data_o,
  output logic                           busy_o
);

  localparam int slots = depth - 2;
  localparam int cw    = $clog2(max_count + 1);
  localparam int kw    = $clog2(depth - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPRESS, DONE} state_t;

  state_t           state_reg, state_next;
  logic [width-1:0] s_reg, c_reg, res_reg;
  logic [kw-1:0]    k_reg;
  logic [cw-1:0]    remaining_reg;
  logic [slots-1:0] fill_reg;
  logic [width-1:0] slot_reg [slots];
  logic [cw-1:0]    count_sat;
  logic             last_op;
  logic             clear_slots;

  logic [width-1:0] ops     [depth];
  logic [width-1:0] s_chain [depth-1];
  logic [width-1:0] c_chain [depth-1];
  logic [width-1:0] maj     [depth-1];
  logic [width-1:0] s_next, c_next;

  assign count_sat   = (count_i > cw'(max_count)) ? cw'(max_count) : count_i;
  assign last_op     = (k_reg == kw'(depth - 3)) || (remaining_reg == cw'(1));
  assign clear_slots = (state_reg == COMPRESS) || (state_reg == IDLE && start_valid_i);

  // Operand slots; the fill bit masks slots not written in the current pass.
  genvar gi;
  generate
    for (gi = 0; gi < slots; gi++) begin : g_slot
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          slot_reg[gi] <= '0;
          fill_reg[gi] <= 1'b0;
        end else if (state_reg == COLLECT && op_valid_i && k_reg == kw'(gi)) begin
          slot_reg[gi] <= op_data_i;
          fill_reg[gi] <= 1'b1;
        end else if (clear_slots) begin
          slot_reg[gi] <= '0;
          fill_reg[gi] <= 1'b0;
        end
      end
      assign ops[gi] = fill_reg[gi] ? slot_reg[gi] : '0;
    end
  endgenerate

  assign ops[depth-2] = s_reg;
  assign ops[depth-1] = c_reg;

  // Chain of 3:2 full-adder rows reduces depth operands to one S/C pair.
  assign s_chain[0] = ops[0];
  assign c_chain[0] = ops[1];
  assign maj[0]     = '0;
  generate
    for (gi = 2; gi < depth; gi++) begin : g_csa
      assign s_chain[gi-1] = s_chain[gi-2] ^ c_chain[gi-2] ^ ops[gi];
      assign maj[gi-1]     = (s_chain[gi-2] & c_chain[gi-2]) |
                             (s_chain[gi-2] & ops[gi]) |
                             (c_chain[gi-2] & ops[gi]);
      assign c_chain[gi-1] = {maj[gi-1][width-2:0], 1'b0};
    end
  endgenerate

  assign s_next = s_chain[depth-2];
  assign c_next = c_chain[depth-2];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    start_ready_o = 1'b0;
    op_ready_o    = 1'b0;
    res_valid_o   = 1'b0;
    busy_o        = 1'b1;
    case (state_reg)
      IDLE: begin
        start_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (start_valid_i) state_next = (count_sat == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        op_ready_o = 1'b1;
        if (op_valid_i && last_op) state_next = COMPRESS;
      end
      COMPRESS: state_next = (remaining_reg == '0) ? DONE : COLLECT;
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_reg         <= '0;
      c_reg         <= '0;
      k_reg         <= '0;
      remaining_reg <= '0;
      res_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start_valid_i) begin
          s_reg         <= '0;
          c_reg         <= '0;
          k_reg         <= '0;
          remaining_reg <= count_sat;
          res_reg       <= '0;
        end
        COLLECT: if (op_valid_i) begin
          k_reg         <= k_reg + kw'(1);
          remaining_reg <= remaining_reg - cw'(1);
        end
        COMPRESS: begin
          s_reg <= s_next;
          c_reg <= c_next;
          k_reg <= '0;
          if (remaining_reg == '0) res_reg <= s_next + c_next;
        end
        default: ;
      endcase
    end
  end

  assign res_data_o = res_reg;

endmodule

// File: tb/tb_csv_accum_ctrl.sv
// Randomised and directed jobs on depth-4 and depth-5 instances, checked
// against an arithmetic model of sum, pass count and latency.
module tb_csv_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       op_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic       sel = 1'b0;
  logic [4:0] count = '0;
  logic [7:0] op_data = '0;

  logic       sr4, or4, rv4, b4, sr5, or5, rv5, b5;
  logic [7:0] rd4, rd5;
  logic       start_ready, op_ready, res_valid, busy;
  logic [7:0] res_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] op_mem [16];

  always #5 clk = ~clk;

  csv_accum_ctrl #(.width(8), .depth(4), .max_count(16)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .start_valid_i(start_valid && !sel), .start_ready_o(sr4), .count_i(count),
    .op_valid_i(op_valid), .op_ready_o(or4), .op_data_i(op_data),
    .res_valid_o(rv4), .res_ready_i(res_ready), .res_data_o(rd4), .busy_o(b4)
  );

  csv_accum_ctrl #(.width(8), .depth(5), .max_count(16)) dut5 (
    .clk_i(clk), .rst_ni(rst_n),
    .start_valid_i(start_valid && sel), .start_ready_o(sr5), .count_i(count),
    .op_valid_i(op_valid), .op_ready_o(or5), .op_data_i(op_data),
    .res_valid_o(rv5), .res_ready_i(res_ready), .res_data_o(rd5), .busy_o(b5)
  );

  assign start_ready = sel ? sr5 : sr4;
  assign op_ready    = sel ? or5 : or4;
  assign res_valid   = sel ? rv5 : rv4;
  assign busy        = sel ? b5  : b4;
  assign res_data    = sel ? rd5 : rd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_start_ready"}, start_ready, 1);
    chk({tag, "_op_ready"}, op_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Runs one job from IDLE using op_mem; called at a negedge, returns at a negedge.
  task automatic run_job(input int req, input int gap_pct, input int hold, input string tag);
    int n, d, exp_comp, exp_lat, cyc, idx, comp;
    bit saw_ready;
    logic [7:0] exp_sum;
    n = (req > 16) ? 16 : req;
    d = sel ? 5 : 4;
    exp_sum = 8'(0);
    for (int i = 0; i < n; i++) exp_sum = exp_sum + op_mem[i];
    exp_comp = (n + d - 3) / (d - 2);
    exp_lat = n + exp_comp + 1;
    chk({tag, "_start_ready"}, start_ready, 1);
    start_valid = 1'b1;
    count = 5'(req);
    @(negedge clk);
    start_valid = 1'b0;
    count = 5'($urandom);
    cyc = 1; idx = 0; comp = 0; saw_ready = 0;
    while (cyc < 500) begin
      if (op_ready) saw_ready = 1;
      if (busy && !op_ready && !res_valid) comp++;
      if (res_valid) break;
      if (op_ready && idx < n && $urandom_range(99) >= gap_pct) begin
        op_valid = 1'b1;
        op_data = op_mem[idx];
        idx++;
      end else begin
        op_valid = 1'b0;
        op_data = 8'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    op_valid = 1'b0;
    if (cyc >= 500) chk({tag, "_timeout"}, res_valid, 1);
    if (gap_pct == 0) chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_compress_passes"}, comp, exp_comp);
    chk({tag, "_saw_op_ready"}, saw_ready, (n > 0));
    chk({tag, "_sum"}, res_data, exp_sum);
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      @(negedge clk);
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_data"}, res_data, exp_sum);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_idle({tag, "_after"});
    $display("job %s: depth=%0d n=%0d sum=%0h passes=%0d cycles=%0d", tag, d, n, res_data, comp, cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset4");
    chk("reset4_data", rd4, 0);
    sel = 1'b1;
    check_idle("reset5");
    chk("reset5_data", rd5, 0);
    sel = 1'b0;

    op_mem[0] = 8'd10; op_mem[1] = 8'd20; op_mem[2] = 8'd30;
    run_job(3, 0, 0, "n3");

    for (int i = 0; i < 4; i++) op_mem[i] = 8'hFF;
    run_job(4, 0, 0, "wrap");

    run_job(0, 0, 0, "empty");

    for (int i = 0; i < 16; i++) op_mem[i] = 8'h11;
    run_job(16, 40, 5, "full_gaps");

    // Abort a job after one compress pass has left S/C non-zero.
    start_valid = 1'b1; count = 5'd5;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_valid = 1'b1; op_data = 8'h5A;
      @(negedge clk);
    end
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_collect", op_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("abort");
    chk("abort_data", res_data, 0);
    op_mem[0] = 8'd1; op_mem[1] = 8'd2;
    run_job(2, 0, 0, "post_abort");

    for (int i = 0; i < 16; i++) op_mem[i] = 8'($urandom);
    run_job(25, 0, 1, "saturate");

    sel = 1'b1;
    for (int i = 0; i < 7; i++) op_mem[i] = 8'(i + 1);
    run_job(7, 0, 0, "d5_n7");

    for (int j = 0; j < 8; j++) begin
      sel = j[0];
      for (int i = 0; i < 16; i++) op_mem[i] = 8'($urandom);
      run_job($urandom_range(16), (j % 3 == 0) ? 0 : 30, $urandom_range(3), $sformatf("rand%0d", j));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csv_accum_ctrl.md
Name: csv_accum_ctrl

Overview:
Sequencer that sums a job of N operands by time-multiplexing one internal AddMopCsv (depth-operand carry-save compressor). Two compressor inputs are fed back from registered sum/carry vectors. Each compress pass therefore absorbs up to depth-2 new operands from a valid/ready stream. After the last pass it resolves S+C with one carry-propagate add and returns the width-bit result (mod 2^width) on a valid/ready output.

Parameters:
width, 16, operand/result word width (>=2)
depth, 4, compressor operand count (>=3); new operands per pass = depth-2
max_count, 16, maximum operands per job (>=1)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  synchronous active-low reset
start_valid_i  input  1  job request
start_ready_o  output  1  high only in IDLE
count_i  input  $clog2(max_count+1)  operands in job; sampled on start handshake; values >max_count saturate to max_count
op_valid_i  input  1  operand valid
op_ready_o  output  1  high only in COLLECT
op_data_i  input  width  operand
res_valid_o  output  1  result valid (DONE)
res_ready_i  input  1  result accept
res_data_o  output  width  sum of job operands mod 2^width
busy_o  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_ni low at a clock edge): state=IDLE, S/C regs=0, slot index=0, remaining=0, res_data_o=0. Outputs after reset: start_ready_o=1, op_ready_o=0, res_valid_o=0, busy_o=0. Reset mid-job drops all partial state; no result is produced.
- IDLE: on start_valid_i&&start_ready_o: clear S,C and slot regs, load remaining=count. Next state = COLLECT if count>0, else DONE with res_data_o=0.
- COLLECT: each op handshake writes op_data_i to slot[k], k++, remaining--. Go to COMPRESS the cycle after the handshake that fills slot depth-3 or makes remaining 0. op_valid_i without the handshake changes nothing.
- COMPRESS (exactly 1 cycle, op_ready_o=0):
  - compressor inputs = {slots, S, C}; unfilled slots are forced to 0.
  - S,C <= compressor S,C; k=0; slots cleared.
  - If remaining==0: res_data_o <= S_next+C_next (width-bit, carry out discarded), go to DONE. Else go to COLLECT.
- DONE: res_valid_o=1; res_data_o stable until res_ready_i. On handshake go to IDLE. start_valid_i is ignored outside IDLE.
- Throughput with no stalls:
  - N operands take N accept cycles + ceil(N/(depth-2)) compress cycles.
  - res_valid_o rises the cycle after the final COMPRESS.
  - Example (depth=4, N=3): start handshake cycle 0; ops accepted cycles 1,2; COMPRESS 3; op accepted 4; COMPRESS 5; res_valid_o cycle 6.
- Output zero-cycle paths: no combinational path from any input to any output. All outputs are decoded from registered state only.
- Overflow wraps silently; no status flag.

Test Plan:
- width=8, depth=4, count=3, ops 10,20,30, valids always high -> res_data_o=60, res_valid_o rises in cycle 6 relative to start handshake.
- count=4, four ops 0xFF -> res_data_o=0xFC (wrap); exactly 2 COMPRESS cycles observed.
- count=0 start -> no op_ready_o ever asserted, DONE next cycle with res_data_o=0.
- count=16, ops all 0x11, random op_valid_i gaps and res_ready_i held low 5 cycles -> res_data_o=0x10 held stable with res_valid_o high until accepted, then start_ready_o=1 next cycle.
- Reset asserted during COLLECT after 2 of 5 ops -> next cycle IDLE, busy_o=0. A new job with count=2, ops 1,2 -> 3; no residue from the aborted job.
- depth=5, count=7, ops 1..7 -> 28, with 3 COMPRESS passes (3+3+1; third pass has 2 zero-padded slots).
